input_conditioner: RTL and testbench
====================================

# input_conditioner

Conditions the four raw board switches (SW1..SW4) into clean, single-hop move requests for `movement_player`. It sits directly upstream of the player-movement block. Each switch is synchronised and debounced. Each debounced press becomes one move event, with auto-repeat while the switch is held. The four directions are arbitrated onto one valid/ready request channel, so the player never receives two hops in one cycle.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before the debounced level changes (10 ms at 25 MHz).
- `REPEAT_DELAY`, default 12500000: cycles a switch must be held after its press event before the first repeat event (500 ms).
- `REPEAT_PERIOD`, default 3750000: cycles between subsequent repeat events (150 ms).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `CLK` in 1: main 25 MHz clock.
  - `RST` in 1: asynchronous, active-high reset.
- `SW1` in 1: raw up switch, active-high, asynchronous to `CLK`.
- `SW2` in 1: raw down switch.
- `SW3` in 1: raw left switch.
- `SW4` in 1: raw right switch.
- `held` out 4: debounced levels {right, left, down, up}, registered.
- `move_valid` out 1: a move request is presented.
- `move_dir` out 2: request direction; 0 = up, 1 = down, 2 = left, 3 = right.
- `move_ready` in 1: the consumer accepts the request.

## Operation
- Reset values: `held` = 0, `move_valid` = 0, `move_dir` = 0. All pending bits, counters and synchroniser flops are also 0.
- Synchroniser: a 2-flop synchroniser per switch.
- Debounce, per channel:
  - Counter `cnt` clears whenever the synchronised input equals `held[i]`.
  - Otherwise `cnt` increments.
  - When `cnt` reaches `DEBOUNCE_CYCLES-1`, `held[i]` toggles and `cnt` clears.
- Repeat FSM, per channel:
  - IDLE: on a 0->1 transition of `held[i]`, emit event and go to DELAY.
  - DELAY: the timer counts to `REPEAT_DELAY-1`, then emits event and goes to REPEAT.
  - REPEAT: the timer counts to `REPEAT_PERIOD-1`, then emits event and restarts.
  - A 1->0 transition of `held[i]` in any state returns to IDLE, clears the timer and emits no event.
- Pending register `pending[3:0]`:
  - An event sets its bit.
  - An event for a direction that is already pending merges and is lost, with no counting.
- Arbiter (output slot):
  - The slot is free when `move_valid`=0, or when `move_valid`=1 and `move_ready`=1.
  - When free, the slot loads the lowest-index set pending bit (up > down > left > right). It asserts `move_valid` with that `move_dir` and clears that pending bit.
  - If no bit is pending, `move_valid` drops to 0.
- Handshake rules:
  - `move_valid` and `move_dir` remain stable until accepted.
  - `move_ready` is ignored while `move_valid`=0.
- Simultaneous events:
  - An event on the same cycle its pending bit is loaded leaves the bit set, so the new event survives.
  - Simultaneous presses on several switches are served one per accepted transfer, in priority order.
- A switch already pressed at reset release produces a press event after the normal debounce time.
- All counters are sized with `$clog2` of their parameter. They saturate-free wrap only via their explicit clear.

## Timing
- Raw edge sampled at edge k:
  - Synchronised value at k+2.
  - `held` updates at k+1+`DEBOUNCE_CYCLES`, for a clean input.
  - The event sets pending on the same edge `held` changes.
  - `move_valid` rises on the next edge, if the slot is free.
- Transfer back-to-back throughput: one request per cycle while `move_ready`=1 and bits are pending.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes `held`.
- Reset asserted mid-operation: all state clears immediately (asynchronously). No request is emitted on release until a new debounce completes.

## Structure
- `constants.v` holds `DIR_UP`, `DIR_DOWN`, `DIR_LEFT`, `DIR_RIGHT` (2-bit codes 0..3), shared with `movement_player`.
- `constants.v` also holds the default debounce and repeat cycle counts.
- One sub-module, `debounce_channel`, instantiated four times. It contains the synchroniser, debounce counter and repeat FSM, and outputs `held` and a one-cycle `event`.
- The pending register and the arbiter live in `input_conditioner`.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, with `move_ready`=1 unless stated.
- Clean press: SW1 rises and holds 10 cycles -> `held[0]` rises exactly 5 cycles after the sampling edge. One `move_valid` pulse follows with `move_dir`=0.
- Bounce: SW2 toggles every 2 cycles for 12 cycles, then stays high -> exactly one request with `move_dir`=1, issued after the final stable period.
- Auto-repeat: SW3 held 60 cycles -> requests with `move_dir`=2 at press, +20, +28, +36, +44, +52. No request after release.
- Priority and backpressure: SW1 and SW4 pressed on the same cycle with `move_ready`=0 -> `move_valid`=1 with `move_dir`=0 held stable. Raising `move_ready` gives dir 0, then dir 3 on the next cycle.
- Merge: SW4 repeat events accumulate while `move_ready`=0 for 40 cycles -> only one dir-3 request after ready rises.
- Reset mid-hold: `RST` pulsed during REPEAT -> all outputs 0 at once. Switch still high -> a new press request arrives one debounce later.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared direction codes and default timing for the switch conditioner and the player block.
package input_conditioner_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // 10 ms, 500 ms and 150 ms at 25 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_REPEAT_DELAY    = 12500000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 3750000;

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  // Fixed priority: up > down > left > right.
  function automatic logic [1:0] lowest_dir(input logic [3:0] req);
    if (req[0])      return DIR_UP;
    else if (req[1]) return DIR_DOWN;
    else if (req[2]) return DIR_LEFT;
    else             return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch: 2-flop synchroniser, debounce counter and press/auto-repeat event generator.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic held,
  output logic evt
);

  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  localparam logic [CntW-1:0] CntLast    = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] DelayLast  = TmrW'(REPEAT_DELAY - 1);
  localparam logic [TmrW-1:0] PeriodLast = TmrW'(REPEAT_PERIOD - 1);

  logic            sync1_q, sync2_q;
  logic            held_q, held_d, toggle;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  rep_state_e      state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      state_q <= StIdle;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    toggle = 1'b0;
    if (sync2_q == held_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d  = '0;
      toggle = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign held_d = held_q ^ toggle;
  assign held   = held_q;

  // A release overrides any event due on the same cycle.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    evt     = 1'b0;
    if (toggle && held_q) begin
      state_d = StIdle;
      tmr_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (toggle) begin
            evt     = 1'b1;
            state_d = StDelay;
            tmr_d   = '0;
          end
        end
        StDelay: begin
          if (tmr_q == DelayLast) begin
            evt     = 1'b1;
            state_d = StRepeat;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        StRepeat: begin
          if (tmr_q == PeriodLast) begin
            evt   = 1'b1;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          tmr_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Four debounced switches feeding a pending register and a single valid/ready move request slot.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  output logic [3:0] held,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready
);

  logic [3:0] sw_raw, held_w, evt;
  logic [3:0] pending_q, pending_d, grant;
  logic       valid_q, valid_d, slot_free;
  logic [1:0] dir_q, dir_d;

  assign sw_raw = {SW4, SW3, SW2, SW1};

  for (genvar g = 0; g < 4; g++) begin : gen_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk (CLK),
      .rst (RST),
      .sw  (sw_raw[g]),
      .held(held_w[g]),
      .evt (evt[g])
    );
  end

  // The slot loads from already-registered pending bits; a new event on the
  // same cycle survives because it is OR-ed in after the grant is cleared.
  always_comb begin
    slot_free = ~valid_q | move_ready;
    valid_d   = valid_q;
    dir_d     = dir_q;
    grant     = '0;
    if (slot_free) begin
      valid_d = |pending_q;
      if (|pending_q) begin
        dir_d = lowest_dir(pending_q);
        grant = 4'b0001 << dir_d;
      end
    end
    pending_d = (pending_q & ~grant) | evt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      dir_q     <= DIR_UP;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      dir_q     <= dir_d;
    end
  end

  assign held       = held_w;
  assign move_valid = valid_q;
  assign move_dir   = dir_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: table, directed corner sequences and random stimulus vs a model.
module tb_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] sw;
  logic       ready;
  logic [3:0] held;
  logic       move_valid;
  logic [1:0] move_dir;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW1       (sw[0]),
    .SW2       (sw[1]),
    .SW3       (sw[2]),
    .SW4       (sw[3]),
    .held      (held),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .move_ready(ready)
  );

  always #5 CLK = ~CLK;

  // Reference model: run lengths, time since press and a set of pending directions.
  logic [3:0] syncq[$];
  logic [3:0] m_held;
  int         run[4];
  int         since[4];
  logic [3:0] m_pend;
  logic       m_valid;
  logic [1:0] m_dir;

  task automatic model_reset();
    syncq.delete();
    syncq.push_back(4'h0);
    syncq.push_back(4'h0);
    m_held  = '0;
    m_pend  = '0;
    m_valid = 1'b0;
    m_dir   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      run[i]   = 0;
      since[i] = -1;
    end
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic [3:0] ev;
    logic [3:0] grant;
    bit         changed;
    int         idx;
    s     = syncq[0];
    ev    = '0;
    grant = '0;
    void'(syncq.pop_front());
    syncq.push_back(sw);
    for (int i = 0; i < 4; i++) begin
      changed = 0;
      if (s[i] == m_held[i]) run[i] = 0;
      else begin
        run[i]++;
        if (run[i] == D) begin
          run[i]    = 0;
          changed   = 1;
          m_held[i] = ~m_held[i];
          if (m_held[i]) begin
            since[i] = 0;
            ev[i]    = 1'b1;
          end else since[i] = -1;
        end
      end
      if (!changed && since[i] >= 0) begin
        since[i]++;
        if (since[i] == RD || (since[i] > RD && (since[i] - RD) % RP == 0)) ev[i] = 1'b1;
      end
    end
    if (!m_valid || ready) begin
      if (m_pend != 0) begin
        idx = 3;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) idx = i;
        m_valid    = 1'b1;
        m_dir      = 2'(idx);
        grant[idx] = 1'b1;
      end else m_valid = 1'b0;
    end
    m_pend = (m_pend & ~grant) | ev;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else model_step();
    #1;
    check("model", {25'd0, held, move_valid, move_dir}, {25'd0, m_held, m_valid, m_dir});
  endtask

  task automatic pulse_reset(input string name);
    #2;
    RST = 1'b1;
    #1;
    check(name, {25'd0, held, move_valid, move_dir}, 32'd0);
    model_reset();
    tick();
    RST = 1'b0;
  endtask

  typedef struct {
    logic [3:0] sw;
    logic       ready;
    logic [3:0] held;
    logic       valid;
    logic [1:0] dir;
  } vec_t;

  vec_t tbl[10];
  int   n, t_held, t_req;
  int   vt[$];
  int   exp_off[6];
  int   idx;

  initial begin
    // Clean press of SW1: held at sampling edge + 5, one request the edge after.
    tbl[0] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[1] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[2] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[3] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[4] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[5] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[6] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[7] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[8] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[9] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0};
    exp_off = '{0, 20, 28, 36, 44, 52};

    RST   = 1'b1;
    sw    = '0;
    ready = 1'b1;
    model_reset();
    tick();
    check("reset_held", {28'd0, held}, 32'd0);
    check("reset_valid", {31'd0, move_valid}, 32'd0);
    check("reset_dir", {30'd0, move_dir}, 32'd0);
    tick();
    RST = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 10; i++) begin
      sw    = tbl[i].sw;
      ready = tbl[i].ready;
      tick();
      check("clean_held", {28'd0, held}, {28'd0, tbl[i].held});
      check("clean_valid", {31'd0, move_valid}, {31'd0, tbl[i].valid});
      if (tbl[i].valid) check("clean_dir", {30'd0, move_dir}, {30'd0, tbl[i].dir});
    end
    sw = '0;
    repeat (12) tick();

    // Bounce on SW2: only the final stable level produces a request.
    n     = 0;
    t_req = -1;
    for (int t = 0; t < 28; t++) begin
      sw = (t >= 12 || (t / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      if (move_valid && move_dir == 2'd1) begin
        n++;
        t_req = t;
      end
    end
    check("bounce_requests", n, 1);
    check("bounce_req_cycle", t_req, 18);
    sw = '0;
    repeat (12) tick();

    // Auto-repeat on SW3 held for 60 cycles.
    vt.delete();
    for (int t = 0; t < 100; t++) begin
      sw = (t < 60) ? 4'b0100 : 4'b0000;
      tick();
      if (move_valid && move_dir == 2'd2) vt.push_back(t);
    end
    check("repeat_count", vt.size(), 6);
    if (vt.size() > 0) check("repeat_first", vt[0], 6);
    for (int j = 1; j < 6 && j < vt.size(); j++)
      check("repeat_offset", vt[j] - vt[0], exp_off[j]);

    // Priority with backpressure: SW1 and SW4 together.
    ready = 1'b0;
    sw    = 4'b1001;
    for (int t = 0; t < 12; t++) begin
      if (t == 10) ready = 1'b1;
      tick();
      if (t >= 6 && t <= 9) begin
        check("prio_stall_valid", {31'd0, move_valid}, 32'd1);
        check("prio_stall_dir", {30'd0, move_dir}, 32'd0);
      end
      if (t == 10) begin
        check("prio_second_valid", {31'd0, move_valid}, 32'd1);
        check("prio_second_dir", {30'd0, move_dir}, 32'd3);
      end
      if (t == 11) check("prio_drain", {31'd0, move_valid}, 32'd0);
    end
    sw = '0;
    repeat (12) tick();

    // Merge: repeats at +20/+28/+36 pile onto one pending bit while stalled.
    // The slot still holds the press request, so two transfers follow.
    ready = 1'b1;
    sw    = 4'b1000;
    n     = 0;
    for (int t = 0; t < 60; t++) begin
      if (t == 7) ready = 1'b0;
      if (t == 47) ready = 1'b1;
      if (t == 49) sw = '0;
      if (t >= 47 && t <= 49 && move_valid && ready) begin
        n++;
        check("merge_dir", {30'd0, move_dir}, 32'd3);
      end
      tick();
    end
    check("merge_transfers", n, 2);
    repeat (10) tick();

    // Reset while SW1 is in auto-repeat; still held, so it re-presses after debounce.
    sw = 4'b0001;
    repeat (35) tick();
    pulse_reset("midhold_reset");
    t_held = -1;
    t_req  = -1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (held[0] && t_held < 0) t_held = t;
      if (move_valid && t_req < 0) t_req = t;
    end
    check("midhold_held_rise", t_held, 5);
    check("midhold_req", t_req, 6);
    sw = '0;
    repeat (12) tick();

    // Random switch activity, random backpressure, occasional reset.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        idx     = $urandom_range(0, 3);
        sw[idx] = ~sw[idx];
      end
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) pulse_reset("random_reset");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
